bus_reply_ctl: RTL and testbench
================================

BUS_REPLY_CTL -- requirements
Module: bus_reply_ctl

Interface
REQ-001 SHALL have parameter RAM_TOP, default 16'o100000: addresses below it are claimed as RAM.
REQ-002 SHALL have parameter WAIT_STATES, default 2: minimum ce-cycles from mem_req to the reply.
REQ-003 SHALL have parameter BUS_TIMEOUT, default 63: ce-cycles before an unclaimed access raises an error.
REQ-004 Ports (name dir width meaning):
- clk in 1: sole clock, rising edge.
- reset in 1: asynchronous, active-high reset.
- ce in 1: clock enable; state advances only when ce=1.
- sync in 1: CPU address strobe.
- din in 1: CPU read strobe.
- dout in 1: CPU write strobe.
- wtbt in 1: byte operation.
- addr in 16: CPU address.
- wdata in 16: CPU write data.
- rply out 1: reply to the CPU.
- rdata out 16: read data to the CPU.
- bus_error out 1: one-cycle error pulse to the CPU error_i.
- mem_req out 1: RAM access strobe.
- mem_we out 1: RAM write.
- mem_be out 2: byte enables, [0]=low byte, [1]=high byte.
- mem_addr out 15: word address, addr[15:1].
- mem_wdata out 16: RAM write data.
- mem_rdata in 16: RAM read data.
- mem_ready in 1: RAM data valid / write done.

Function
REQ-005 SHALL implement an FSM with states IDLE, ACCESS, WAIT, REPLY, HOLD and ERROR; every transition below is taken on a clk edge with ce=1.
REQ-006 IDLE: when sync=1 and exactly one of din/dout is 1, the block SHALL latch addr, wdata, wtbt and the direction, then go to ACCESS if addr<RAM_TOP, otherwise go to WAIT with the unclaimed flag set.
REQ-007 IDLE with sync=1, din=1 and dout=1 SHALL go to ERROR; sync=1 with neither strobe SHALL stay in IDLE.
REQ-008 ACCESS: the block SHALL assert mem_req for exactly one ce-cycle, load the wait counter with WAIT_STATES, and go to WAIT.
REQ-009 mem_be: 2'b11 for any read or a word write; for a byte write, 2'b01 when addr[0]=0 and 2'b10 when addr[0]=1.
REQ-010 mem_wdata SHALL equal latched wdata; mem_we=1 only for writes; mem_addr, mem_we and mem_be SHALL stay stable from ACCESS until REPLY.
REQ-011 WAIT (claimed access): decrement the counter to zero; when the counter is 0 and mem_ready=1, capture mem_rdata into rdata for reads and go to REPLY.
REQ-012 If mem_ready=1 arrives before the counter reaches 0, the block SHALL register it and reply when the counter reaches 0.
REQ-013 REPLY: rply SHALL be 1 from entry to REPLY until sync=0 is sampled; REPLY then goes to HOLD on the next ce-cycle.
REQ-014 HOLD: rply=1 while sync=1; when sync=0, drop rply and return to IDLE; rdata SHALL stay unchanged until the next read capture.
REQ-015 sync falling in ACCESS or WAIT (CPU abort) SHALL return the FSM to IDLE with rply=0 and no error pulse; a pending mem_ready SHALL be discarded.
REQ-016 ERROR: bus_error=1 for exactly one ce-cycle, then return to IDLE; rply SHALL never be asserted for an errored access.
REQ-017 rply SHALL never be 1 while the FSM is in IDLE.

Reset
REQ-018 reset=1 SHALL immediately force the FSM to IDLE with rply=0, bus_error=0, mem_req=0, mem_we=0, mem_be=0, rdata=0 and all counters and flags at 0, independent of clk and ce.
REQ-019 Reset asserted mid-access SHALL abandon the access; after release the block SHALL wait for a new sync rising in IDLE.

Configuration
REQ-020 Macro BUS_REPLY_TIMEOUT_EN controls the unclaimed-access watchdog.
- Defined: an unclaimed access counts BUS_TIMEOUT ce-cycles in WAIT, then goes to ERROR; sync falling earlier returns to IDLE silently.
- Undefined: an unclaimed access stays in WAIT with rply=0 until sync=0, and ERROR is reachable only via REQ-007.

Verification
REQ-021 Word read at 16'o001000, mem_rdata=16'o123456, mem_ready held 1, ce=1 -> mem_req 1 cycle after sync sampled; rply 2 cycles after mem_req; rdata=16'o123456; rply drops the cycle after sync=0.
REQ-022 Byte writes of 16'o000377 to addr 16'o002001 with wtbt=1 -> mem_be=2'b10, mem_we=1, mem_addr=15'o001000; the same write to 16'o002000 -> mem_be=2'b01.
REQ-023 mem_ready delayed 5 cycles after mem_req -> rply rises exactly 1 ce-cycle after mem_ready is sampled; a ce toggling 1010 doubles the wall-clock latency with the same ce-cycle counts.
REQ-024 Read at 16'o177700 with BUS_REPLY_TIMEOUT_EN defined -> bus_error pulses once, 63 ce-cycles after WAIT entry, and rply stays 0; with the macro undefined -> no pulse, and the FSM returns to IDLE when sync drops.
REQ-025 sync=1 with din=dout=1 -> bus_error pulse and no mem_req; reset=1 asserted during WAIT -> rply, mem_req and bus_error are 0 immediately and the FSM is IDLE.

Source files
------------

// File: rtl/bus_reply_ctl.sv
// CPU bus reply controller: claims RAM below RAM_TOP, paces replies with wait states and
// flags protocol errors. Optional unclaimed-access watchdog: define BUS_REPLY_TIMEOUT_EN.
module bus_reply_ctl #(
    parameter logic [15:0] RAM_TOP     = 16'o100000,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned BUS_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        sync,
    input  logic        din,
    input  logic        dout,
    input  logic        wtbt,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        rply,
    output logic [15:0] rdata,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned CNT_MAX = (WAIT_STATES > BUS_TIMEOUT) ? WAIT_STATES : BUS_TIMEOUT;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_REPLY,
        S_HOLD,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               latch, capture;
    logic               unclaimed_q;
    logic               rd_q;
    logic               we_q;
    logic [1:0]         be_q;
    logic [14:0]        addr_q;
    logic [15:0]        wdata_q;
    logic               ready_seen_q;
    logic [15:0]        rdbuf_q;
    logic [15:0]        rdata_q;
    logic               sync_low_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch     = 1'b0;
        capture   = 1'b0;
        rply      = 1'b0;
        bus_error = 1'b0;
        mem_req   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // sync_low_q makes a held sync (after reset or an error) wait for a fresh rising edge
                if (sync && sync_low_q) begin
                    if (din && dout) begin
                        state_d = S_ERROR;
                    end else if (din ^ dout) begin
                        latch = 1'b1;
                        if (addr < RAM_TOP) begin
                            state_d = S_ACCESS;
                            cnt_d   = CNT_W'(WAIT_STATES);
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = CNT_W'(BUS_TIMEOUT);
                        end
                    end
                end
            end
            S_ACCESS: begin
                mem_req = 1'b1;
                // the wait counter already runs during the strobe cycle so WAIT_STATES spans mem_req to rply
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                state_d = sync ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!sync) begin
                    state_d = S_IDLE;
                end else if (!unclaimed_q) begin
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    if ((cnt_q <= CNT_W'(1)) && (mem_ready || ready_seen_q)) begin
                        capture = 1'b1;
                        state_d = S_REPLY;
                    end
                end else begin
`ifdef BUS_REPLY_TIMEOUT_EN
                    if (cnt_q <= CNT_W'(1)) state_d = S_ERROR;
                    else                    cnt_d   = cnt_q - 1'b1;
`endif
                end
            end
            S_REPLY: begin
                rply    = 1'b1;
                state_d = sync ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                rply = 1'b1;
                if (!sync) state_d = S_IDLE;
            end
            S_ERROR: begin
                bus_error = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            unclaimed_q  <= 1'b0;
            rd_q         <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ready_seen_q <= 1'b0;
            rdbuf_q      <= '0;
            rdata_q      <= '0;
            sync_low_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!sync)
                sync_low_q <= 1'b1;
            else if ((state_q == S_IDLE) && (state_d != S_IDLE))
                sync_low_q <= 1'b0;
            if (latch) begin
                unclaimed_q  <= (addr >= RAM_TOP);
                rd_q         <= din;
                we_q         <= dout;
                be_q         <= (!dout || !wtbt) ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
                addr_q       <= addr[15:1];
                wdata_q      <= wdata;
                ready_seen_q <= 1'b0;
            end else if (((state_q == S_ACCESS) || (state_q == S_WAIT)) && !unclaimed_q
                         && mem_ready && !ready_seen_q) begin
                ready_seen_q <= 1'b1;
                rdbuf_q      <= mem_rdata;
            end
            if (capture && rd_q)
                rdata_q <= ready_seen_q ? rdbuf_q : mem_rdata;
        end
    end

    assign rdata     = rdata_q;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_bus_reply_ctl.sv
// Self-checking bench for bus_reply_ctl: randomized accesses against timing rules
// computed from wait states, ready delay and sync hold length.
module tb_bus_reply_ctl;

    localparam logic [15:0] RT = 16'o100000;
    localparam int WS = 2;
    localparam int TO = 63;

    logic        clk = 1'b0;
    logic        reset, ce, sync, din, dout, wtbt, mem_ready;
    logic [15:0] addr, wdata, mem_rdata;
    logic        rply, bus_error, mem_req, mem_we;
    logic [15:0] rdata, mem_wdata;
    logic [1:0]  mem_be;
    logic [14:0] mem_addr;

    int          n_checks = 0;
    int          n_fail = 0;
    int          clk_count = 0;
    bit          slow = 1'b0;
    logic [15:0] last_rd = '0;

    bus_reply_ctl #(.RAM_TOP(RT), .WAIT_STATES(WS), .BUS_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ce(ce), .sync(sync), .din(din), .dout(dout),
        .wtbt(wtbt), .addr(addr), .wdata(wdata), .rply(rply), .rdata(rdata),
        .bus_error(bus_error), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) clk_count++;

    // one ce-cycle; with slow set, ce toggles 0,1 so each ce-cycle takes two clocks
    task automatic step();
        if (slow) begin
            ce = 1'b0;
            @(posedge clk); #1;
        end
        ce = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        sync = 0; din = 0; dout = 0; mem_ready = 0;
        repeat (n) step();
    endtask

    function automatic int reply_at(input int r);
        return (r + 1 > 1 + WS) ? r + 1 : 1 + WS;
    endfunction

    task automatic test_reset();
        reset = 1; ce = 0; sync = 0; din = 0; dout = 0; wtbt = 0;
        addr = '0; wdata = '0; mem_rdata = '0; mem_ready = 0;
        #3;
        n_checks++; if (rply !== 1'b0) begin n_fail++; $display("FAIL reset_rply got %b want 0", rply); end
        n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_bus_error got %b want 0", bus_error); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        n_checks++; if (mem_be !== 2'b00) begin n_fail++; $display("FAIL reset_mem_be got %b want 00", mem_be); end
        n_checks++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0000", rdata); end
        repeat (2) @(posedge clk);
        #1 reset = 0;
        last_rd = '0;
        idle(2);
    endtask

    task automatic test_read();
        logic [15:0] a, d;
        int r, hold, exp_r, drop;
        logic e;
        for (int n = 0; n < 6; n++) begin
            if (n == 0) begin a = 16'o001000; d = 16'o123456; r = 1; hold = 1; end
            else begin
                a = 16'($urandom_range(0, 32767)); d = 16'($urandom);
                r = $urandom_range(1, 7); hold = $urandom_range(0, 3);
            end
            exp_r = reply_at(r); drop = exp_r + hold;
            sync = 1; din = 1; dout = 0; addr = a; wtbt = 1'($urandom_range(0, 1));
            for (int t = 1; t <= drop + 1; t++) begin
                step();
                e = (t == 1);
                n_checks++; if (mem_req !== e) begin n_fail++; $display("FAIL rd_mem_req n=%0d t=%0d got %b want %b", n, t, mem_req, e); end
                e = (t >= exp_r) && (t <= drop);
                n_checks++; if (rply !== e) begin n_fail++; $display("FAIL rd_rply n=%0d t=%0d got %b want %b", n, t, rply, e); end
                n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rd_bus_error n=%0d t=%0d got %b want 0", n, t, bus_error); end
                if (t == 1) begin
                    n_checks++;
                    if ({mem_we, mem_be, mem_addr} !== {1'b0, 2'b11, a[15:1]}) begin
                        n_fail++; $display("FAIL rd_mem_ctl n=%0d got we=%b be=%b addr=%o want we=0 be=11 addr=%o", n, mem_we, mem_be, mem_addr, a[15:1]);
                    end
                    n_checks++; if (rdata !== last_rd) begin n_fail++; $display("FAIL rd_rdata_hold n=%0d got %h want %h", n, rdata, last_rd); end
                end
                if (t == exp_r) begin
                    n_checks++; if (rdata !== d) begin n_fail++; $display("FAIL rd_rdata n=%0d got %o want %o", n, rdata, d); end
                end
                mem_ready = (t >= r);
                mem_rdata = (t >= r) ? d : 16'($urandom);
                if (t == drop) begin sync = 0; din = 0; end
            end
            last_rd = d; mem_ready = 0;
        end
    endtask

    task automatic test_byte_write();
        logic [15:0] a, w;
        logic bt, e;
        logic [1:0] exp_be;
        int r, exp_r, drop;
        for (int n = 0; n < 6; n++) begin
            if (n < 2) begin a = (n == 0) ? 16'o002001 : 16'o002000; w = 16'o000377; bt = 1; end
            else begin a = 16'($urandom_range(0, 32767)); w = 16'($urandom); bt = 1'($urandom_range(0, 1)); end
            exp_be = bt ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
            r = $urandom_range(1, 5); exp_r = reply_at(r); drop = exp_r + 1;
            sync = 1; din = 0; dout = 1; addr = a; wdata = w; wtbt = bt;
            for (int t = 1; t <= drop + 1; t++) begin
                step();
                e = (t == 1);
                n_checks++; if (mem_req !== e) begin n_fail++; $display("FAIL wr_mem_req n=%0d t=%0d got %b want %b", n, t, mem_req, e); end
                e = (t >= exp_r) && (t <= drop);
                n_checks++; if (rply !== e) begin n_fail++; $display("FAIL wr_rply n=%0d t=%0d got %b want %b", n, t, rply, e); end
                n_checks++; if (rdata !== last_rd) begin n_fail++; $display("FAIL wr_rdata_hold n=%0d t=%0d got %h want %h", n, t, rdata, last_rd); end
                if (t <= exp_r) begin
                    n_checks++;
                    if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, exp_be, a[15:1], w}) begin
                        n_fail++;
                        $display("FAIL wr_mem_ctl n=%0d t=%0d got we=%b be=%b addr=%o wd=%o want we=1 be=%b addr=%o wd=%o",
                                 n, t, mem_we, mem_be, mem_addr, mem_wdata, exp_be, a[15:1], w);
                    end
                end
                mem_ready = (t >= r);
                mem_rdata = 16'($urandom);
                if (t == drop) begin sync = 0; dout = 0; end
            end
            mem_ready = 0; wtbt = 0;
        end
    endtask

    task automatic test_ce_toggle();
        logic [15:0] a, d;
        int r, exp_r, drop, c0, rise;
        logic e;
        slow = 1;
        a = 16'($urandom_range(0, 32767)); d = 16'($urandom);
        r = 6; exp_r = reply_at(r); drop = exp_r + 2; rise = -1;
        sync = 1; din = 1; dout = 0; addr = a;
        c0 = clk_count;
        for (int t = 1; t <= drop + 1; t++) begin
            step();
            if (rply === 1'b1 && rise < 0) rise = clk_count - c0;
            e = (t == 1);
            n_checks++; if (mem_req !== e) begin n_fail++; $display("FAIL ce_mem_req t=%0d got %b want %b", t, mem_req, e); end
            e = (t >= exp_r) && (t <= drop);
            n_checks++; if (rply !== e) begin n_fail++; $display("FAIL ce_rply t=%0d got %b want %b", t, rply, e); end
            mem_ready = (t >= r);
            mem_rdata = (t >= r) ? d : 16'($urandom);
            if (t == drop) begin sync = 0; din = 0; end
        end
        n_checks++; if (rise !== 2 * exp_r) begin n_fail++; $display("FAIL ce_wall_latency got %0d clocks want %0d", rise, 2 * exp_r); end
        n_checks++; if (rdata !== d) begin n_fail++; $display("FAIL ce_rdata got %h want %h", rdata, d); end
        last_rd = d; mem_ready = 0;
        slow = 0;
        idle(2);
    endtask

    task automatic test_proto_error();
        logic e;
        sync = 1; din = 1; dout = 1; addr = 16'($urandom_range(0, 32767));
        for (int t = 1; t <= 5; t++) begin
            step();
            e = (t == 1);
            n_checks++; if (bus_error !== e) begin n_fail++; $display("FAIL perr_bus_error t=%0d got %b want %b", t, bus_error, e); end
            n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL perr_mem_req t=%0d got %b want 0", t, mem_req); end
            n_checks++; if (rply !== 1'b0) begin n_fail++; $display("FAIL perr_rply t=%0d got %b want 0", t, rply); end
        end
        sync = 0; din = 0; dout = 0;
        step();
        sync = 1;
        for (int t = 1; t <= 3; t++) begin
            step();
            n_checks++; if ({mem_req, bus_error} !== 2'b00) begin n_fail++; $display("FAIL nostrobe_idle t=%0d got req=%b err=%b want 0 0", t, mem_req, bus_error); end
        end
        din = 1;
        step();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL late_strobe_mem_req got %b want 1", mem_req); end
        idle(3);
    endtask

    task automatic test_abort();
        logic [15:0] d;
        int cut, r, exp_r;
        logic e;
        cut = $urandom_range(1, 2);
        sync = 1; din = 1; dout = 0; addr = 16'($urandom_range(0, 32767));
        for (int t = 1; t <= cut + 2; t++) begin
            step();
            n_checks++; if ({rply, bus_error} !== 2'b00) begin n_fail++; $display("FAIL abort_quiet t=%0d got rply=%b err=%b want 0 0", t, rply, bus_error); end
            mem_ready = (t == 1);
            mem_rdata = ~last_rd;
            if (t == cut) begin sync = 0; din = 0; end
        end
        mem_ready = 0;
        n_checks++; if (rdata !== last_rd) begin n_fail++; $display("FAIL abort_rdata got %h want %h", rdata, last_rd); end
        d = 16'($urandom); r = 5; exp_r = reply_at(r);
        sync = 1; din = 1; addr = 16'($urandom_range(0, 32767));
        for (int t = 1; t <= exp_r; t++) begin
            step();
            e = (t >= exp_r);
            n_checks++; if (rply !== e) begin n_fail++; $display("FAIL post_abort_rply t=%0d got %b want %b", t, rply, e); end
            mem_ready = (t >= r);
            mem_rdata = (t >= r) ? d : 16'($urandom);
        end
        n_checks++; if (rdata !== d) begin n_fail++; $display("FAIL post_abort_rdata got %h want %h", rdata, d); end
        last_rd = d;
        idle(3);
    endtask

    task automatic test_unclaimed();
        logic [15:0] a;
        int drop, exp_err;
        logic e;
        for (int n = 0; n < 2; n++) begin
            if (n == 0) begin a = 16'o177700; drop = 70; end
            else begin a = 16'($urandom_range(32768, 65535)); drop = $urandom_range(2, 40); end
`ifdef BUS_REPLY_TIMEOUT_EN
            exp_err = (drop >= TO + 1) ? TO + 1 : -1;
`else
            exp_err = -1;
`endif
            sync = 1; din = 1; dout = 0; addr = a;
            for (int t = 1; t <= drop + 1; t++) begin
                step();
                e = (t == exp_err);
                n_checks++; if (bus_error !== e) begin n_fail++; $display("FAIL unc_bus_error n=%0d t=%0d got %b want %b", n, t, bus_error, e); end
                n_checks++; if ({rply, mem_req} !== 2'b00) begin n_fail++; $display("FAIL unc_quiet n=%0d t=%0d got rply=%b req=%b want 0 0", n, t, rply, mem_req); end
                mem_ready = 1'($urandom_range(0, 1));
                if (t == drop) begin sync = 0; din = 0; end
            end
            mem_ready = 0;
            sync = 1; din = 1; addr = 16'o000100;
            step();
            n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL unc_back_to_idle n=%0d got mem_req=%b want 1", n, mem_req); end
            idle(3);
        end
    endtask

    task automatic test_reset_mid();
        sync = 1; din = 1; dout = 0; addr = 16'($urandom_range(0, 32767));
        step(); step();
        #2 reset = 1;
        #1;
        n_checks++; if ({rply, mem_req, bus_error} !== 3'b000) begin n_fail++; $display("FAIL rst_wait_outs got rply=%b req=%b err=%b want 0 0 0", rply, mem_req, bus_error); end
        n_checks++; if ({mem_we, mem_be, rdata} !== 19'h0) begin n_fail++; $display("FAIL rst_wait_regs got we=%b be=%b rdata=%h want zeros", mem_we, mem_be, rdata); end
        @(posedge clk); #1 reset = 0;
        for (int t = 1; t <= 4; t++) begin
            step();
            n_checks++; if ({mem_req, rply} !== 2'b00) begin n_fail++; $display("FAIL rst_no_restart t=%0d got req=%b rply=%b want 0 0", t, mem_req, rply); end
        end
        sync = 0; step();
        sync = 1; mem_ready = 1; mem_rdata = 16'($urandom) | 16'h0001;
        for (int t = 1; t <= 4; t++) step();
        n_checks++; if (rply !== 1'b1) begin n_fail++; $display("FAIL rst_hold_rply got %b want 1", rply); end
        ce = 0;
        #2 reset = 1;
        #1;
        n_checks++; if ({rply, rdata} !== 17'h0) begin n_fail++; $display("FAIL rst_hold_async got rply=%b rdata=%h want 0 0000", rply, rdata); end
        @(posedge clk); #1 reset = 0;
        last_rd = '0;
        idle(3);
    endtask

    initial begin
        test_reset();
        test_read();
        test_byte_write();
        test_ce_toggle();
        test_proto_error();
        test_abort();
        test_unclaimed();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
